// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes rxd, times start/data/stop sampling and
// strobes an external 10-bit right-shift register, then validates the frame.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rxd,
  output logic       sr_shift,
  output logic       sr_sdi,
  input  logic [9:0] sr_q,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CHECK
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bitcnt;
  logic          r_armed;
  logic          r_sync1;
  logic          r_sync2;
  logic [7:0]    r_data;
  logic          r_data_valid;
  logic          r_frame_err;
  logic          r_busy;

  logic w_rxd_s;
  logic w_start_hit;
  logic w_bit_hit;
  logic w_shift;
  logic w_frame_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s     = r_sync2;
  assign w_start_hit = (r_state == S_START) && (r_cnt == C_HALF_M1);
  assign w_bit_hit   = (r_state == S_DATA) && (r_cnt == C_BIT_M1);
  assign w_frame_ok  = !sr_q[0] && sr_q[9];

  // The shift strobe is decoded in the sampling cycle itself so that sr_q is
  // already complete when CHECK is evaluated one cycle after the stop sample.
  assign w_shift  = (w_start_hit && !w_rxd_s) || w_bit_hit;
  assign sr_shift = w_shift;
  assign sr_sdi   = w_rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bitcnt     <= '0;
      r_armed      <= 1'b1;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_rxd_s) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_bitcnt <= '0;
          if (en && r_armed && !w_rxd_s) begin
            r_state <= S_START;
            r_armed <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_start_hit) begin
            r_cnt <= '0;
            if (!w_rxd_s) begin
              r_state  <= S_DATA;
              r_bitcnt <= 4'd1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_hit) begin
            r_cnt    <= '0;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd9) begin
              r_state <= S_CHECK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_bitcnt <= '0;
          if (w_frame_ok) begin
            r_data       <= sr_q[8:1];
            r_data_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
            // A low stop bit with the line still low is a break: wait for idle.
            if (!w_rxd_s) begin
              r_armed <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

  a_pulse_excl : assert property (@(posedge clk) disable iff (rst)
    !(data_valid && frame_err));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl with an external shift register model.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  // raw rxd edge -> rxd_s (2) -> START (1) -> mid-start (HALF) -> 9 bits -> CHECK -> pulse
  localparam int unsigned LAT  = 2 + 1 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       rxd = 1'b1;
  logic       sr_shift;
  logic       sr_sdi;
  logic [9:0] sr_q = '0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  dval;
    int unsigned at;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl_last = 8'h00;
  int         mon_shifts = 0;
  logic       prev_shift = 1'b0;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rxd       (rxd),
    .sr_shift  (sr_shift),
    .sr_sdi    (sr_sdi),
    .sr_q      (sr_q),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sr_shift) sr_q <= {sr_sdi, sr_q[9:1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the first nbits bits of a frame; if expect_out, queues the result.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned stop_len,
                            input int unsigned gap, input int unsigned nbits, input bit expect_out);
    logic [9:0] bits;
    exp_t e;
    bits = {stop, b, 1'b0};
    if (expect_out) begin
      e.is_err = !stop;
      if (stop) mdl_last = b;
      e.dval = mdl_last;
      e.at   = cyc + LAT;
      sb.push_back(e);
    end
    for (int unsigned i = 0; i < nbits; i++) begin
      rxd = bits[i];
      tick((i == 9) ? stop_len : CPB);
    end
    if (nbits == 10) begin
      rxd = 1'b1;
      tick(gap);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_shifts = 0;
      prev_shift = 1'b0;
    end else begin
      if (sr_shift) begin
        check("shift_not_consecutive", {31'd0, prev_shift}, 32'd0);
        mon_shifts++;
      end
      prev_shift = sr_shift;
      if (data_valid || frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {30'd0, data_valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("out_kind_valid", {31'd0, data_valid}, {31'd0, !e.is_err});
          check("out_data", {24'd0, data}, {24'd0, e.dval});
          check("out_cycle", cyc, e.at);
          check("shift_count", mon_shifts, 10);
          mon_shifts = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    int          busy_cnt;
    int unsigned first_busy;
    int          wait_cnt;

    // Reset values
    tick(1);
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_dv", {31'd0, data_valid}, 32'd0);
      check("rst_fe", {31'd0, frame_err}, 32'd0);
      check("rst_shift", {31'd0, sr_shift}, 32'd0);
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_sdi", {31'd0, sr_sdi}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4);

    // Nominal frame
    send_frame(8'hA5, 1'b1, CPB, 6, 10, 1'b1);
    @(negedge clk);
    check("a5_busy_after", {31'd0, busy}, 32'd0);
    check("a5_data_after", {24'd0, data}, 32'hA5);
    tick(1);

    // False start: 4 low cycles
    n0 = cyc;
    busy_cnt = 0;
    first_busy = 0;
    fork
      begin
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (busy) begin
            busy_cnt++;
            if (first_busy == 0) first_busy = cyc;
          end
        end
      end
    join
    check("false_start_busy_cycles", busy_cnt, 8);
    check("false_start_busy_first", first_busy, n0 + 3);
    tick(3);

    // Break: low stop bit held 40 cycles must not retrigger
    n0 = cyc;
    fork
      send_frame(8'h3C, 1'b0, 40, 8, 10, 1'b1);
      begin
        while (cyc < n0 + LAT + 1) @(negedge clk);
        repeat (29) begin
          check("break_no_restart", {31'd0, busy}, 32'd0);
          @(negedge clk);
        end
      end
    join
    check("break_data_held", {24'd0, data}, 32'hA5);

    // Reset mid-frame after the 5th shift
    send_frame(8'h81, 1'b1, CPB, 0, 5, 1'b0);
    rst = 1'b1;
    rxd = 1'b1;
    mdl_last = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_outs", {29'd0, data_valid, frame_err, sr_shift}, 32'd0);
      check("midrst_data", {24'd0, data}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4);
    send_frame(8'h81, 1'b1, CPB, 4, 10, 1'b1);

    // Back-to-back frames with zero gap
    send_frame(8'h00, 1'b1, CPB, 0, 10, 1'b1);
    send_frame(8'hFF, 1'b1, CPB, 4, 10, 1'b1);

    // Receive disabled during a whole frame, then enabled
    en = 1'b0;
    fork
      send_frame(8'h55, 1'b1, CPB, 4, 10, 1'b0);
      repeat (160) begin
        @(negedge clk);
        check("en_off_idle", {31'd0, busy}, 32'd0);
      end
    join
    en = 1'b1;
    tick(2);
    send_frame(8'h55, 1'b1, CPB, 4, 10, 1'b1);

    // Randomized frames with occasional bad stop bits
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic stop;
      int unsigned gap;
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap = stop ? $urandom_range(0, 12) : $urandom_range(2, 12);
      send_frame(b, stop, CPB, gap, 10, 1'b1);
    end

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("scoreboard_drained", sb.size(), 0);
    tick(2);
    check("final_data", {24'd0, data}, {24'd0, mdl_last});
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
